shared_mem_arbiter: RTL and testbench
=====================================

# shared_mem_arbiter

Round-robin arbiter that lets the GPU cores share one single-port shared-memory SRAM. It sits between the per-core load/store request ports (`mem_req_ld`/`mem_req_st`, 12-bit address, 8-bit data, `val_data` completion pulse) and the SRAM macro. It serialises accesses, returns read data, and guarantees that each request level is serviced exactly once, even if a core leaves its request asserted after completion.

## Interface
- `N_CORES`, default 16: number of requesting cores.
- `ADDR_W`, default 12: shared-memory address width.
- `DATA_W`, default 8: data width.
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high.
- `req_ld`  in  N_CORES  per-core load request; level, held until `val_data`.
- `req_st`  in  N_CORES  per-core store request; level.
- `req_addr`  in  N_CORES*ADDR_W  packed addresses; core k is at `[k*ADDR_W +: ADDR_W]`.
- `req_wdata`  in  N_CORES*DATA_W  packed store data, same packing.
- `val_data`  out  N_CORES  one-hot completion pulse, one cycle.
- `rdata`  out  DATA_W  broadcast load data; valid with `val_data`, held until the next load completes.
- `sram_en`  out  1  SRAM access strobe.
- `sram_we`  out  1  1 = write.
- `sram_addr`  out  ADDR_W  SRAM address.
- `sram_wdata`  out  DATA_W  SRAM write data.
- `sram_rdata`  in  DATA_W  SRAM read data; valid one cycle after a read strobe.
- `busy`  out  1  high when the FSM is not in IDLE.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- Eligible vector: `(req_ld | req_st) & ~served`.
- IDLE: if any core is eligible, pick winner g with the round-robin picker, register g, op, address and wdata, then go to ACCESS. Otherwise stay in IDLE.
- ACCESS: assert `sram_en` for one cycle. `sram_we` = store. Drive the registered address and wdata. Go to RESP.
- RESP:
  - Pulse `val_data[g]`.
  - For a load, capture `sram_rdata` into `rdata`.
  - Set `served[g]`.
  - Set pointer = (g+1) mod N_CORES.
  - Arbitrate again, excluding g: if any core is eligible, register the new winner and go to ACCESS; else go to IDLE.
- Round-robin search starts at the pointer and wraps at N_CORES-1 → 0.
- `served[k]` clears in any cycle where `req_ld[k]|req_st[k]` = 0. A core must drop its request for at least one cycle before it can be serviced again. This makes a stuck-high request harmless.
- A core with both `req_ld` and `req_st` high is treated as a load.
- Request changes after the grant is registered are ignored until RESP.

## Timing
- Reset values:
  - state IDLE, pointer 0, `served` all 0.
  - `val_data` 0, `rdata` 0, `sram_en` 0, `sram_we` 0, `sram_addr` 0, `sram_wdata` 0, `busy` 0.
- Latency with the request first seen in IDLE at cycle t: `sram_en` at t+1, `val_data`/`rdata` at t+2.
- Back-to-back throughput: one access per 2 cycles (RESP→ACCESS).
- `sram_en`, `sram_we`, `sram_addr` and `sram_wdata` are registered outputs. `sram_we` is 0 outside ACCESS. Address and wdata hold their last value.
- Reset mid-operation: return to IDLE next cycle. No `val_data` pulse is produced for the aborted access. `served` and pointer are cleared.
- Single requester: serviced, then blocked by `served` until it deasserts for at least one cycle.

## Structure
- Shared package `gpu_mem_pkg` holds:
  - `ADDR_W` and `DATA_W` defaults, also used by the cores.
  - The arbiter state encoding: IDLE=0, ACCESS=1, RESP=2.
  - Opcode constants LD=11 and ST=13.
- Sub-module `rr_picker`: combinational; inputs are the eligible vector and the pointer; outputs are `any` and `winner` index. Reused by future arbiters.

## Test plan
- Single load: core 3 `req_ld`, addr 0x0A5, SRAM[0x0A5]=0x3C → `sram_en`/`we`=0 at t+1, `val_data`=0x0008 and `rdata`=0x3C at t+2.
- Store then load: core 0 stores 0x77 to 0x100 (`sram_we`=1 at t+1). Core 0 drops its request for 1 cycle, then loads 0x100 → `rdata`=0x77.
- Contention: cores 1, 5 and 15 request at once with pointer 0 → service order 1, 5, 15. A `val_data` pulse appears every 2 cycles.
- Wrap-around: pointer 14, cores 2 and 15 request → order 15, 2.
- Stuck request: core 7 holds `req_st` high for 20 cycles → exactly one `val_data[7]` pulse. After a 1-cycle drop and a re-assert → a second pulse.
- Reset during ACCESS: no `val_data` pulse. Outputs return to their reset values the next cycle. A pending request is re-serviced after reset releases.

Source files
------------

// File: rtl/gpu_mem_pkg.sv
// Shared definitions for the GPU shared-memory path: default widths,
// arbiter state encoding and load/store opcodes.
package gpu_mem_pkg;

   localparam int ADDR_W = 12;
   localparam int DATA_W = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } arbState_t;

   localparam logic [3:0] LD = 4'd11;
   localparam logic [3:0] ST = 4'd13;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first eligible index at or after the
// pointer, wrapping from N-1 back to 0.
module rr_picker #(
   parameter int N     = 16,
   parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     eligible_i,
   input  logic [IDX_W-1:0] ptr_i,
   output logic             any_o,
   output logic [IDX_W-1:0] winner_o
);

   int cand;

   // Scan from the farthest offset down to the pointer so the nearest hit wins.
   always_comb begin
      any_o    = |eligible_i;
      winner_o = '0;
      cand     = 0;
      for (int i = N - 1; i >= 0; i--) begin
         cand = int'(ptr_i) + i;
         if (cand >= N) cand = cand - N;
         if (eligible_i[cand[IDX_W-1:0]]) winner_o = cand[IDX_W-1:0];
      end
   end

endmodule

// File: rtl/shared_mem_arbiter.sv
// Round-robin arbiter serialising per-core load/store requests onto one
// single-port SRAM; each request level is serviced exactly once.
module shared_mem_arbiter #(
   parameter int N_CORES = 16,
   parameter int ADDR_W  = gpu_mem_pkg::ADDR_W,
   parameter int DATA_W  = gpu_mem_pkg::DATA_W
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [N_CORES-1:0]    req_ld_i,
   input  logic [N_CORES-1:0]    req_st_i,
   input  logic [N_CORES*ADDR_W-1:0] req_addr_i,
   input  logic [N_CORES*DATA_W-1:0] req_wdata_i,
   output logic [N_CORES-1:0]    val_data_o,
   output logic [DATA_W-1:0]     rdata_o,
   output logic                  sram_en_o,
   output logic                  sram_we_o,
   output logic [ADDR_W-1:0]     sram_addr_o,
   output logic [DATA_W-1:0]     sram_wdata_o,
   input  logic [DATA_W-1:0]     sram_rdata_i,
   output logic                  busy_o
);

   import gpu_mem_pkg::*;

   localparam int IDX_W = (N_CORES > 1) ? $clog2(N_CORES) : 1;

   arbState_t            state_q;
   logic [IDX_W-1:0]     ptr_q;
   logic [IDX_W-1:0]     grant_q;
   logic [3:0]           op_q;
   logic [N_CORES-1:0]   served_q;
   logic [N_CORES-1:0]   served_d;
   logic [N_CORES-1:0]   valData_q;
   logic [DATA_W-1:0]    rdata_q;
   logic                 sramEn_q;
   logic                 sramWe_q;
   logic [ADDR_W-1:0]    sramAddr_q;
   logic [DATA_W-1:0]    sramWdata_q;

   logic [ADDR_W-1:0]    coreAddr [N_CORES];
   logic [DATA_W-1:0]    coreWdata [N_CORES];
   logic [N_CORES-1:0]   reqAny;
   logic [N_CORES-1:0]   grantOneHot;
   logic [N_CORES-1:0]   eligible;
   logic [IDX_W-1:0]     nextPtr;
   logic [IDX_W-1:0]     pickPtr;
   logic                 pickAny;
   logic [IDX_W-1:0]     pickWinner;
   logic                 launch;

   for (genvar k = 0; k < N_CORES; k++) begin : g_unpack
      assign coreAddr[k]  = req_addr_i[k*ADDR_W +: ADDR_W];
      assign coreWdata[k] = req_wdata_i[k*DATA_W +: DATA_W];
   end

   // In RESP the current grantee is still unmarked in served_q, so it is
   // masked out explicitly and the search restarts just past it.
   always_comb begin
      reqAny      = req_ld_i | req_st_i;
      grantOneHot = '0;
      grantOneHot[grant_q] = 1'b1;
      nextPtr  = (grant_q == IDX_W'(N_CORES - 1)) ? '0 : grant_q + 1'b1;
      pickPtr  = (state_q == RESP) ? nextPtr : ptr_q;
      eligible = reqAny & ~served_q & ((state_q == RESP) ? ~grantOneHot : '1);
      launch   = pickAny && (state_q == IDLE || state_q == RESP);
      served_d = served_q & reqAny;
      if (state_q == RESP) served_d = served_d | grantOneHot;
   end

   rr_picker #(.N(N_CORES), .IDX_W(IDX_W)) u_picker (
      .eligible_i (eligible),
      .ptr_i      (pickPtr),
      .any_o      (pickAny),
      .winner_o   (pickWinner)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         ptr_q       <= '0;
         grant_q     <= '0;
         op_q        <= LD;
         served_q    <= '0;
         valData_q   <= '0;
         rdata_q     <= '0;
         sramEn_q    <= 1'b0;
         sramWe_q    <= 1'b0;
         sramAddr_q  <= '0;
         sramWdata_q <= '0;
      end else begin
         valData_q <= '0;
         sramEn_q  <= 1'b0;
         sramWe_q  <= 1'b0;
         served_q  <= served_d;
         case (state_q)
            IDLE: state_q <= pickAny ? ACCESS : IDLE;
            ACCESS: begin
               valData_q <= grantOneHot;
               state_q   <= RESP;
            end
            RESP: begin
               ptr_q <= nextPtr;
               if (op_q == LD) rdata_q <= sram_rdata_i;
               state_q <= pickAny ? ACCESS : IDLE;
            end
            default: state_q <= IDLE;
         endcase
         if (launch) begin
            grant_q     <= pickWinner;
            op_q        <= req_ld_i[pickWinner] ? LD : ST;
            sramEn_q    <= 1'b1;
            sramWe_q    <= ~req_ld_i[pickWinner];
            sramAddr_q  <= coreAddr[pickWinner];
            sramWdata_q <= coreWdata[pickWinner];
         end
      end
   end

   assign val_data_o   = valData_q;
   assign rdata_o      = (state_q == RESP && op_q == LD) ? sram_rdata_i : rdata_q;
   assign sram_en_o    = sramEn_q;
   assign sram_we_o    = sramWe_q;
   assign sram_addr_o  = sramAddr_q;
   assign sram_wdata_o = sramWdata_q;
   assign busy_o       = (state_q != IDLE);

endmodule

// File: tb/tb_shared_mem_arbiter.sv
// Bench for shared_mem_arbiter: directed cycle table, reset-abort sequence and
// a randomized run against a transaction-level model with its own memory copy.
module tb_shared_mem_arbiter;

   localparam int N  = 16;
   localparam int AW = 12;
   localparam int DW = 8;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic [N-1:0] reqLd = '0;
   logic [N-1:0] reqSt = '0;
   logic [N*AW-1:0] reqAddr;
   logic [N*DW-1:0] reqWdata;
   logic [N-1:0] valData;
   logic [DW-1:0] rdata;
   logic sramEn, sramWe, busy;
   logic [AW-1:0] sramAddr;
   logic [DW-1:0] sramWdata;
   logic [DW-1:0] sramRdata;
   logic memInit = 1'b1;

   logic [AW-1:0] coreAddr [N];
   logic [DW-1:0] coreData [N];
   logic [DW-1:0] sramMem [4096];
   logic [DW-1:0] refMem [4096];

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic [15:0] ld;
      logic [15:0] st;
      logic [15:0] expVal;
      logic        expEn;
      logic        expWe;
      logic        expBusy;
      logic [11:0] expAddr;
      logic        chkR;
      logic [7:0]  expR;
   } vecRow_t;
   vecRow_t vecs[$];

   bit          mOut;
   int          mG, mDone, mPtr, cyc;
   bit          mIsLd;
   logic [11:0] mAddr;
   logic [7:0]  mWdata, mPendRd, mRdata;
   bit [15:0]   mServed, pendingReq;

   always #5 clk = ~clk;

   for (genvar k = 0; k < N; k++) begin : g_pack
      assign reqAddr[k*AW +: AW]  = coreAddr[k];
      assign reqWdata[k*DW +: DW] = coreData[k];
   end

   shared_mem_arbiter #(.N_CORES(N), .ADDR_W(AW), .DATA_W(DW)) dut (
      .clk          (clk),
      .reset        (reset),
      .req_ld_i     (reqLd),
      .req_st_i     (reqSt),
      .req_addr_i   (reqAddr),
      .req_wdata_i  (reqWdata),
      .val_data_o   (valData),
      .rdata_o      (rdata),
      .sram_en_o    (sramEn),
      .sram_we_o    (sramWe),
      .sram_addr_o  (sramAddr),
      .sram_wdata_o (sramWdata),
      .sram_rdata_i (sramRdata),
      .busy_o       (busy)
   );

   function automatic logic [7:0] memPattern(input logic [11:0] a);
      if (a == 12'h0A5) return 8'h3C;
      if (a[11:4] == 8'h01) return {4'h4, a[3:0]};
      return a[7:0] ^ {a[11:8], a[11:8]} ^ 8'hA5;
   endfunction

   // Single-port SRAM with one-cycle registered read data.
   always @(posedge clk) begin
      if (memInit) begin
         for (int i = 0; i < 4096; i++) sramMem[i] <= memPattern(12'(i));
      end else if (sramEn) begin
         if (sramWe) sramMem[sramAddr] <= sramWdata;
         sramRdata <= sramMem[sramAddr];
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input logic [15:0] ld, input logic [15:0] st);
      reqLd = ld;
      reqSt = st;
   endtask

   task automatic addRow(input logic [15:0] ld, input logic [15:0] st, input logic [15:0] val,
                         input logic en, input logic we, input logic bsy,
                         input logic [11:0] addr, input logic chkR, input logic [7:0] r);
      vecs.push_back('{ld, st, val, en, we, bsy, addr, chkR, r});
   endtask

   // Transaction-level model: one outstanding access finishing two cycles
   // after its grant; memory effects are applied at grant time in order.
   task automatic modelStep();
      logic [15:0] reqV;
      bit found;
      int k;
      reqV = reqLd | reqSt;
      mServed = mServed & reqV;
      if (mOut && mDone == cyc) begin
         mServed[mG] = 1'b1;
         mPtr = (mG + 1) % N;
         if (mIsLd) mRdata = mPendRd;
         pendingReq[mG] = 1'b0;
         mOut = 1'b0;
      end
      found = 1'b0;
      if (!mOut) begin
         for (int i = 0; i < N; i++) begin
            k = (mPtr + i) % N;
            if (!found && reqV[k] && !mServed[k]) begin
               found  = 1'b1;
               mOut   = 1'b1;
               mG     = k;
               mDone  = cyc + 2;
               mIsLd  = reqLd[k];
               mAddr  = coreAddr[k];
               mWdata = coreData[k];
               if (mIsLd) mPendRd = refMem[mAddr];
               else refMem[mAddr] = mWdata;
            end
         end
      end
   endtask

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int seen;
      logic [15:0] firstVal;
      logic [7:0] rdAt;
      logic [15:0] eVal;
      logic [7:0] eRd;
      bit eEn;
      int sel;

      for (int k = 0; k < N; k++) begin
         coreAddr[k] = 12'h010 + 12'(k);
         coreData[k] = 8'h80 + 8'(k);
      end
      coreAddr[0] = 12'h100;
      coreData[0] = 8'h77;
      coreAddr[3] = 12'h0A5;

      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("reset val_data", 32'(valData), 0);
      checkOutput("reset rdata", 32'(rdata), 0);
      checkOutput("reset sram_en", 32'(sramEn), 0);
      checkOutput("reset sram_we", 32'(sramWe), 0);
      checkOutput("reset sram_addr", 32'(sramAddr), 0);
      checkOutput("reset sram_wdata", 32'(sramWdata), 0);
      checkOutput("reset busy", 32'(busy), 0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      memInit = 1'b0;

      addRow(16'h0008, 0, 0,         0, 0, 0, 0,      0, 0);
      addRow(16'h0008, 0, 0,         1, 0, 1, 12'h0A5, 0, 0);
      addRow(16'h0008, 0, 16'h0008,  0, 0, 1, 0,      1, 8'h3C);
      addRow(0, 0, 0,                0, 0, 0, 0,      1, 8'h3C);
      addRow(0, 1, 0,                0, 0, 0, 0,      0, 0);
      addRow(0, 1, 0,                1, 1, 1, 12'h100, 0, 0);
      addRow(0, 1, 1,                0, 0, 1, 0,      1, 8'h3C);
      addRow(0, 0, 0,                0, 0, 0, 0,      0, 0);
      addRow(1, 0, 0,                0, 0, 0, 0,      0, 0);
      addRow(1, 0, 0,                1, 0, 1, 12'h100, 0, 0);
      addRow(1, 0, 1,                0, 0, 1, 0,      1, 8'h77);
      addRow(0, 0, 0,                0, 0, 0, 0,      0, 0);
      addRow(16'h8022, 0, 0,         0, 0, 0, 0,      0, 0);
      addRow(16'h8022, 0, 0,         1, 0, 1, 12'h011, 0, 0);
      addRow(16'h8022, 0, 16'h0002,  0, 0, 1, 0,      1, 8'h41);
      addRow(16'h8022, 0, 0,         1, 0, 1, 12'h015, 0, 0);
      addRow(16'h8022, 0, 16'h0020,  0, 0, 1, 0,      1, 8'h45);
      addRow(16'h8022, 0, 0,         1, 0, 1, 12'h01F, 0, 0);
      addRow(16'h8022, 0, 16'h8000,  0, 0, 1, 0,      1, 8'h4F);
      addRow(16'h8022, 0, 0,         0, 0, 0, 0,      1, 8'h4F);
      addRow(0, 0, 0,                0, 0, 0, 0,      0, 0);
      addRow(16'h2000, 0, 0,         0, 0, 0, 0,      0, 0);
      addRow(16'h2000, 0, 0,         1, 0, 1, 12'h01D, 0, 0);
      addRow(16'h2000, 0, 16'h2000,  0, 0, 1, 0,      1, 8'h4D);
      addRow(16'h8004, 0, 0,         0, 0, 0, 0,      0, 0);
      addRow(16'h8004, 0, 0,         1, 0, 1, 12'h01F, 0, 0);
      addRow(16'h8004, 0, 16'h8000,  0, 0, 1, 0,      1, 8'h4F);
      addRow(16'h8004, 0, 0,         1, 0, 1, 12'h012, 0, 0);
      addRow(16'h8004, 0, 16'h0004,  0, 0, 1, 0,      1, 8'h42);
      addRow(0, 0, 0,                0, 0, 0, 0,      0, 0);
      addRow(0, 16'h0080, 0,         0, 0, 0, 0,      0, 0);
      addRow(0, 16'h0080, 0,         1, 1, 1, 12'h017, 0, 0);
      addRow(0, 16'h0080, 16'h0080,  0, 0, 1, 0,      0, 0);
      for (int i = 0; i < 17; i++) addRow(0, 16'h0080, 0, 0, 0, 0, 0, 0, 0);
      addRow(0, 0, 0,                0, 0, 0, 0,      0, 0);
      addRow(0, 16'h0080, 0,         0, 0, 0, 0,      0, 0);
      addRow(0, 16'h0080, 0,         1, 1, 1, 12'h017, 0, 0);
      addRow(0, 16'h0080, 16'h0080,  0, 0, 1, 0,      0, 0);
      addRow(0, 0, 0,                0, 0, 0, 0,      1, 8'h42);

      for (int r = 0; r < vecs.size(); r++) begin
         applyStimulus(vecs[r].ld, vecs[r].st);
         @(negedge clk);
         checkOutput($sformatf("vec%0d val_data", r), 32'(valData), 32'(vecs[r].expVal));
         checkOutput($sformatf("vec%0d sram_en", r), 32'(sramEn), 32'(vecs[r].expEn));
         checkOutput($sformatf("vec%0d sram_we", r), 32'(sramWe), 32'(vecs[r].expWe));
         checkOutput($sformatf("vec%0d busy", r), 32'(busy), 32'(vecs[r].expBusy));
         if (vecs[r].expEn) checkOutput($sformatf("vec%0d sram_addr", r), 32'(sramAddr), 32'(vecs[r].expAddr));
         if (vecs[r].chkR) checkOutput($sformatf("vec%0d rdata", r), 32'(rdata), 32'(vecs[r].expR));
         @(posedge clk);
         #1;
      end

      // Reset lands during ACCESS: no completion, outputs cleared, request re-serviced.
      coreAddr[9] = 12'h019;
      applyStimulus(16'h0200, 0);
      @(negedge clk);
      checkOutput("rstSeq idle busy", 32'(busy), 0);
      @(posedge clk);
      #1;
      @(negedge clk);
      checkOutput("rstSeq access en", 32'(sramEn), 1);
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      checkOutput("rstSeq val_data", 32'(valData), 0);
      checkOutput("rstSeq sram_en", 32'(sramEn), 0);
      checkOutput("rstSeq busy", 32'(busy), 0);
      checkOutput("rstSeq sram_addr", 32'(sramAddr), 0);
      checkOutput("rstSeq sram_wdata", 32'(sramWdata), 0);
      checkOutput("rstSeq rdata", 32'(rdata), 0);
      @(posedge clk);
      #1;
      seen = -1;
      firstVal = '0;
      rdAt = '0;
      for (int c = 0; c < 8 && seen < 0; c++) begin
         @(negedge clk);
         if (valData != 0) begin
            seen = c;
            firstVal = valData;
            rdAt = rdata;
         end
         @(posedge clk);
         #1;
      end
      checkOutput("rstSeq reservice latency", 32'(seen), 1);
      checkOutput("rstSeq reservice val_data", 32'(firstVal), 32'h0200);
      checkOutput("rstSeq reservice rdata", 32'(rdAt), 32'h49);
      applyStimulus(0, 0);

      // Randomized run against the model from a fresh reset and memory image.
      reset = 1'b1;
      memInit = 1'b1;
      for (int i = 0; i < 4096; i++) refMem[i] = memPattern(12'(i));
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      memInit = 1'b0;
      mOut = 1'b0; mG = 0; mDone = 0; mPtr = 0; cyc = 0; mIsLd = 1'b0;
      mAddr = '0; mWdata = '0; mPendRd = '0; mRdata = '0;
      mServed = '0; pendingReq = '0;

      for (int n = 0; n < 4000; n++) begin
         for (int k = 0; k < N; k++) begin
            if (reqLd[k] | reqSt[k]) begin
               if (!pendingReq[k] && $urandom_range(0, 2) == 0) begin
                  reqLd[k] = 1'b0;
                  reqSt[k] = 1'b0;
               end
            end else if ($urandom_range(0, 3) == 0) begin
               sel = int'($urandom_range(0, 2));
               reqLd[k] = (sel != 1);
               reqSt[k] = (sel != 0);
               coreAddr[k] = {8'h20, 4'($urandom_range(0, 15))};
               coreData[k] = 8'($urandom);
               pendingReq[k] = 1'b1;
            end
         end
         @(negedge clk);
         eVal = (mOut && mDone == cyc) ? (16'h0001 << mG) : 16'h0000;
         eEn  = mOut && (mDone == cyc + 1);
         eRd  = (mOut && mDone == cyc && mIsLd) ? mPendRd : mRdata;
         checkOutput($sformatf("rand%0d val_data", n), 32'(valData), 32'(eVal));
         checkOutput($sformatf("rand%0d sram_en", n), 32'(sramEn), 32'(eEn));
         checkOutput($sformatf("rand%0d busy", n), 32'(busy), 32'(mOut));
         checkOutput($sformatf("rand%0d rdata", n), 32'(rdata), 32'(eRd));
         checkOutput($sformatf("rand%0d sram_we", n), 32'(sramWe), 32'(eEn && !mIsLd));
         if (eEn) begin
            checkOutput($sformatf("rand%0d sram_addr", n), 32'(sramAddr), 32'(mAddr));
            if (!mIsLd) checkOutput($sformatf("rand%0d sram_wdata", n), 32'(sramWdata), 32'(mWdata));
         end
         modelStep();
         @(posedge clk);
         #1;
         cyc++;
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
